// File: rtl/regfile_fall_pkg.sv
// Shared defaults for the falling-edge register file with pending scoreboard.
package regfile_fall_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int ZERO_IDX   = 0;
endpackage

// File: rtl/regfile_fall_if.sv
// Write, issue and dual read bus for regfile_fall.
interface regfile_fall_if
   import regfile_fall_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
);
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic              iss;
   logic [ADDR_W-1:0] iss_addr;
   logic [ADDR_W-1:0] raddr_a;
   logic [ADDR_W-1:0] raddr_b;
   logic [DATA_W-1:0] rdata_a;
   logic [DATA_W-1:0] rdata_b;
   logic              busy_a;
   logic              busy_b;
   logic              hazard;

   modport master (
      output we, waddr, wdata, iss, iss_addr, raddr_a, raddr_b,
      input  rdata_a, rdata_b, busy_a, busy_b, hazard
   );

   modport slave (
      input  we, waddr, wdata, iss, iss_addr, raddr_a, raddr_b,
      output rdata_a, rdata_b, busy_a, busy_b, hazard
   );
endinterface

// File: rtl/regfile_entry.sv
// One register plus its pending bit; falling-edge state, async active-low clear.
module regfile_entry #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              wr_en,
   input  logic              iss_en,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] data,
   output logic              pend
);

   always_ff @(negedge clk or negedge clr) begin
      if (!clr) begin
         data <= '0;
         pend <= 1'b0;
      end else begin
         if (wr_en)
            data <= wdata;
         // a new issue to the same index outranks the retiring writeback
         if (iss_en)
            pend <= 1'b1;
         else if (wr_en)
            pend <= 1'b0;
      end
   end

endmodule

// File: rtl/regfile_fall.sv
// Register file with per-register pending bits; writes on the falling edge,
// reads combinational so rising-edge logic sees the new value in the same cycle.
module regfile_fall
   import regfile_fall_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic           clk,
   input  logic           clr,
   regfile_fall_if.slave  bus
);

   localparam int NREG = 2 ** ADDR_W;

   logic [NREG-1:ZERO_IDX+1] wr_dec;
   logic [NREG-1:ZERO_IDX+1] iss_dec;
   logic [DATA_W-1:0]        data [NREG];
   logic                     pend [NREG];

   always_comb begin
      wr_dec  = '0;
      iss_dec = '0;
      for (int i = ZERO_IDX + 1; i < NREG; i++) begin
         wr_dec[i]  = bus.we  && (bus.waddr    == ADDR_W'(i));
         iss_dec[i] = bus.iss && (bus.iss_addr == ADDR_W'(i));
      end
   end

   // index zero has no storage: constant zero, never pending
   assign data[ZERO_IDX] = '0;
   assign pend[ZERO_IDX] = 1'b0;

   for (genvar g = ZERO_IDX + 1; g < NREG; g++) begin : g_reg
      regfile_entry #(.DATA_W(DATA_W)) u_entry (
         .clk    (clk),
         .clr    (clr),
         .wr_en  (wr_dec[g]),
         .iss_en (iss_dec[g]),
         .wdata  (bus.wdata),
         .data   (data[g]),
         .pend   (pend[g])
      );
   end

   assign bus.rdata_a = data[bus.raddr_a];
   assign bus.rdata_b = data[bus.raddr_b];
   assign bus.busy_a  = pend[bus.raddr_a];
   assign bus.busy_b  = pend[bus.raddr_b];
   assign bus.hazard  = bus.busy_a | bus.busy_b;

endmodule

// File: tb/tb_regfile_fall.sv
// Self-checking bench for regfile_fall: vector table through a scoreboard queue,
// then hand sequences for asynchronous reset behaviour.
module tb_regfile_fall;

   typedef struct {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        iss;
      logic [4:0]  iss_addr;
      logic [4:0]  raddr_a;
      logic [4:0]  raddr_b;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
      logic        exp_busy_a;
      logic        exp_busy_b;
      logic        exp_hazard;
   } vec_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        busy_a;
      logic        busy_b;
      logic        hazard;
   } exp_t;

   logic clk = 1'b0;
   logic clr = 1'b0;
   int   n_total = 0;
   int   n_pass  = 0;
   exp_t sb_q[$];

   regfile_fall_if #(.DATA_W(32), .ADDR_W(5)) bus ();

   regfile_fall #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic check_outs(input string tag, input exp_t e);
      check({tag, " rdata_a"}, bus.rdata_a, e.a);
      check({tag, " rdata_b"}, bus.rdata_b, e.b);
      check({tag, " busy_a"},  {31'd0, bus.busy_a}, {31'd0, e.busy_a});
      check({tag, " busy_b"},  {31'd0, bus.busy_b}, {31'd0, e.busy_b});
      check({tag, " hazard"},  {31'd0, bus.hazard}, {31'd0, e.hazard});
   endtask

   task automatic drive(input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                        input logic iss, input logic [4:0] iss_addr,
                        input logic [4:0] ra, input logic [4:0] rb);
      bus.we       = we;
      bus.waddr    = waddr;
      bus.wdata    = wdata;
      bus.iss      = iss;
      bus.iss_addr = iss_addr;
      bus.raddr_a  = ra;
      bus.raddr_b  = rb;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t vecs[10];
      exp_t e;

      // state carries from row to row; expectations are post-edge read values
      vecs[0] = '{1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  5'd5,  5'd4,  32'hDEADBEEF, 32'h0,        0, 0, 0};
      vecs[1] = '{1, 5'd0,  32'hFFFFFFFF, 1, 5'd0,  5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 0, 0, 0};
      vecs[2] = '{0, 5'd0,  32'h0,        1, 5'd7,  5'd7,  5'd5,  32'h0,        32'hDEADBEEF, 1, 0, 1};
      vecs[3] = '{0, 5'd7,  32'h55555555, 0, 5'd5,  5'd7,  5'd5,  32'h0,        32'hDEADBEEF, 1, 0, 1};
      vecs[4] = '{1, 5'd7,  32'h77,       0, 5'd0,  5'd7,  5'd7,  32'h77,       32'h77,       0, 0, 0};
      vecs[5] = '{1, 5'd9,  32'h12,       1, 5'd9,  5'd9,  5'd7,  32'h12,       32'h77,       1, 0, 1};
      vecs[6] = '{1, 5'd3,  32'hA,        1, 5'd31, 5'd31, 5'd9,  32'h0,        32'h12,       1, 1, 1};
      vecs[7] = '{1, 5'd31, 32'hB,        0, 5'd0,  5'd31, 5'd3,  32'hB,        32'hA,        0, 0, 0};
      vecs[8] = '{1, 5'd9,  32'h99,       1, 5'd3,  5'd9,  5'd3,  32'h99,       32'hA,        0, 1, 1};
      vecs[9] = '{1, 5'd3,  32'h33,       0, 5'd0,  5'd3,  5'd31, 32'h33,       32'hB,        0, 0, 0};

      drive(0, 5'd0, 32'h0, 0, 5'd0, 5'd5, 5'd7);
      #2;
      check_outs("reset", '{32'h0, 32'h0, 0, 0, 0});

      @(posedge clk); #2;
      clr = 1'b1;

      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         drive(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].iss, vecs[i].iss_addr,
               vecs[i].raddr_a, vecs[i].raddr_b);
         sb_q.push_back('{vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_busy_a,
                          vecs[i].exp_busy_b, vecs[i].exp_hazard});
         @(negedge clk); #1;
         e = sb_q.pop_front();
         check_outs($sformatf("vec%0d", i), e);
      end

      // state unchanged before the falling edge: no write visible at rising edge
      @(posedge clk); #1;
      drive(1, 5'd3, 32'hCAFE0000, 1, 5'd20, 5'd3, 5'd20);
      check("pre-edge rdata_a", bus.rdata_a, 32'h33);
      check("pre-edge busy_b",  {31'd0, bus.busy_b}, 32'd0);
      @(negedge clk); #1;
      check("post-edge rdata_a", bus.rdata_a, 32'hCAFE0000);
      check("post-edge hazard",  {31'd0, bus.hazard}, 32'd1);

      // mid-cycle async reset clears everything before any clock edge
      drive(0, 5'd0, 32'h0, 0, 5'd0, 5'd3, 5'd20);
      @(posedge clk); #2;
      clr = 1'b0;
      #1;
      check_outs("async reset", '{32'h0, 32'h0, 0, 0, 0});
      bus.raddr_a = 5'd5;
      bus.raddr_b = 5'd31;
      #1;
      check("reset r5",  bus.rdata_a, 32'h0);
      check("reset r31", bus.rdata_b, 32'h0);

      // write and issue during reset are dropped
      drive(1, 5'd5, 32'h5A5A5A5A, 1, 5'd5, 5'd5, 5'd5);
      @(negedge clk); #1;
      check_outs("write in reset", '{32'h0, 32'h0, 0, 0, 0});

      // release mid-cycle: nothing changes until the next falling edge
      @(posedge clk); #2;
      clr = 1'b1;
      #1;
      check("release pre-edge data", bus.rdata_a, 32'h0);
      check("release pre-edge busy", {31'd0, bus.busy_a}, 32'd0);
      @(negedge clk); #1;
      check("release post-edge data", bus.rdata_a, 32'h5A5A5A5A);
      check("release post-edge busy", {31'd0, bus.busy_a}, 32'd1);

      drive(0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
      @(negedge clk); #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/regfile_fall.md
REGFILE_FALL -- requirements
Module: regfile_fall

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter ADDR_W, default 5, register index width; register count is 2**ADDR_W.
REQ-003 Port clk input 1: single clock; all state updates on the falling edge.
REQ-004 Port clr input 1: clear; reset is asynchronous and active-low (clr=0 resets, clr=1 runs).
REQ-005 Port we input 1: writeback enable.
REQ-006 Port waddr input ADDR_W: writeback destination index.
REQ-007 Port wdata input DATA_W: writeback data.
REQ-008 Port iss input 1: issue strobe; marks register iss_addr pending.
REQ-009 Port iss_addr input ADDR_W: index of the destination being issued.
REQ-010 Port raddr_a input ADDR_W: read port A index.
REQ-011 Port raddr_b input ADDR_W: read port B index.
REQ-012 Port rdata_a output DATA_W: read port A data.
REQ-013 Port rdata_b output DATA_W: read port B data.
REQ-014 Port busy_a output 1: register raddr_a is pending.
REQ-015 Port busy_b output 1: register raddr_b is pending.
REQ-016 Port hazard output 1: busy_a OR busy_b.

Function
REQ-017 Storage SHALL be 2**ADDR_W registers of DATA_W bits plus one pending bit per register.
REQ-018 On a falling clk edge with we=1 and waddr!=0, register waddr SHALL load wdata.
REQ-019 On a falling clk edge with we=1, pending[waddr] SHALL clear.
REQ-020 On a falling clk edge with iss=1 and iss_addr!=0, pending[iss_addr] SHALL set.
REQ-021 Same edge, iss_addr==waddr, both strobes active: data written and pending ends SET (issue wins).
REQ-022 Register 0 SHALL always read 0 and never be pending; writes and issues to index 0 are ignored.
REQ-023 Reads SHALL be combinational: rdata_x = reg[raddr_x], busy_x = pending[raddr_x].
REQ-024 No bypass: data written at a falling edge is visible on rdata_x from that edge onward; rising-edge consumers see it in the same cycle (half-cycle write-before-read).
REQ-025 Both read ports SHALL be independent; identical indices return identical data.
REQ-026 Write latency: one falling edge; scoreboard latency: one falling edge.
REQ-027 we=0 and iss=0 SHALL leave all state unchanged regardless of address inputs.

Reset
REQ-028 clr=0 SHALL immediately, without a clock, clear every register to 0 and every pending bit to 0.
REQ-029 During reset, rdata_a, rdata_b, busy_a, busy_b and hazard SHALL read 0.
REQ-030 clr=0 takes priority over a concurrent falling edge; a write or issue coinciding with reset is dropped.
REQ-031 Reset deassertion mid-cycle SHALL take effect at the next falling edge only.

Structure
REQ-032 DATA_W and ADDR_W defaults and the zero-register index constant SHALL live in the shared CPU package.
REQ-033 One sub-module, regfile_entry (DATA_W data bit-vector plus pending bit, falling-edge, async active-low clear), SHALL be instantiated per register index 1..2**ADDR_W-1.
REQ-034 Decoders for waddr and iss_addr and the read muxes SHALL be in the top level.

Verification
REQ-035 Reset: clr=0 mid-cycle after writes -> all rdata 0, hazard 0 before the next edge.
REQ-036 Write/read: we=1, waddr=5, wdata=0xDEADBEEF, falling edge -> raddr_a=5 gives 0xDEADBEEF; raddr_b=4 gives 0.
REQ-037 Zero register: we=1, waddr=0, wdata=0xFFFFFFFF; iss=1, iss_addr=0 -> rdata_a(0)=0, busy_a=0.
REQ-038 Scoreboard: iss=1, iss_addr=7 -> busy_a=1 and hazard=1 for raddr_a=7; later we=1, waddr=7 -> busy_a=0.
REQ-039 Collision: iss=1, iss_addr=9, we=1, waddr=9, wdata=0x12 on the same edge -> rdata=0x12, busy=1.
REQ-040 Dual read: registers 3=0xA, 31=0xB written; raddr_a=31, raddr_b=3 -> 0xB and 0xA simultaneously.
